decode_stage: RTL and testbench

Second pipeline stage of the 5-stage MIPS core. Consumes the fetch/decode latch (instruction, instr_npc) and holds the 32x32 register file with writeback bypass. Decodes control, resolves jumps and branches early to redirect fetch, detects load-use and branch-operand hazards, and drives the decode/execute pipeline register.

---
 rtl/decode_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage of the 5-stage MIPS core: register file with writeback bypass,
// control decode, early jump/branch resolution, hazard detection and the ID/EX latch.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [3:0] {
    ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
  } aluop_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
    OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
    OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23,
    FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27,
    FN_SLT = 6'h2A, FN_SLTU = 6'h2B
  } funct_t;
endpackage

module decode_stage
  import cpu_types_pkg::*;
#(
  parameter word_t HALT_WORD = 32'hFFFFFFFF
) (
  input  logic     CLK,
  input  logic     nRST,
  input  logic     en,
  input  word_t    instruction,
  input  word_t    instr_npc,
  input  logic     wb_wen,
  input  regbits_t wb_wsel,
  input  word_t    wb_wdat,
  input  logic     ex_wen,
  input  logic     ex_memread,
  input  regbits_t ex_wsel,
  input  logic     mem_memread,
  input  regbits_t mem_wsel,
  output logic     stall,
  output logic     redirect_en,
  output word_t    redirect_pc,
  output logic     squash,
  output logic     halt,
  output word_t    dx_npc,
  output word_t    dx_rdat1,
  output word_t    dx_rdat2,
  output word_t    dx_imm,
  output regbits_t dx_rs,
  output regbits_t dx_rt,
  output regbits_t dx_wsel,
  output aluop_t   dx_aluop,
  output logic     dx_alusrc,
  output logic     dx_shift,
  output logic     dx_wen,
  output logic     dx_memread,
  output logic     dx_memwrite,
  output logic     dx_link,
  output logic     dx_halt
);
  typedef struct packed {
    word_t    npc, rdat1, rdat2, imm;
    regbits_t rs, rt, wsel;
    aluop_t   aluop;
    logic     alusrc, shift, wen, memread, memwrite, link, halt;
  } dx_t;

  word_t    regs [32];
  logic [5:0] op, fn;
  regbits_t rs, rt, rd;
  word_t    sext, zext, rdat1, rdat2;
  dx_t      d, q;
  logic     known, uses_rs, uses_rt, is_beq, is_bne, is_j, is_jr;
  logic     take, load_use, cmp_haz;

  assign op   = instruction[31:26];
  assign fn   = instruction[5:0];
  assign rs   = instruction[25:21];
  assign rt   = instruction[20:16];
  assign rd   = instruction[15:11];
  assign sext = {{16{instruction[15]}}, instruction[15:0]};
  assign zext = {16'h0, instruction[15:0]};

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST)
      regs <= '{default: '0};
    else if (wb_wen && wb_wsel != '0)
      regs[wb_wsel] <= wb_wdat;
  end

  assign rdat1 = (wb_wen && wb_wsel == rs && rs != '0) ? wb_wdat : regs[rs];
  assign rdat2 = (wb_wen && wb_wsel == rt && rt != '0) ? wb_wdat : regs[rt];

  function automatic logic hits(regbits_t w, logic on_rs, logic on_rt, regbits_t s, regbits_t t);
    return (w != '0) && ((on_rs && w == s) || (on_rt && w == t));
  endfunction

  always_comb begin
    d = '0;
    known = 1'b0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_j = 1'b0;
    is_jr = 1'b0;
    if (!halt && instruction != '0) begin
      d.aluop = ALU_ADD;
      known = 1'b1;
      if (instruction == HALT_WORD) begin
        d.halt = 1'b1;
      end else begin
        case (op)
          OP_RTYPE: begin
            d.wen = 1'b1;
            d.wsel = rd;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
            case (fn)
              FN_ADDU: d.aluop = ALU_ADD;
              FN_SUBU: d.aluop = ALU_SUB;
              FN_AND:  d.aluop = ALU_AND;
              FN_OR:   d.aluop = ALU_OR;
              FN_XOR:  d.aluop = ALU_XOR;
              FN_NOR:  d.aluop = ALU_NOR;
              FN_SLT:  d.aluop = ALU_SLT;
              FN_SLTU: d.aluop = ALU_SLTU;
              FN_SLL, FN_SRL: begin
                d.aluop = (fn == FN_SLL) ? ALU_SLL : ALU_SRL;
                d.shift = 1'b1;
                d.imm = {27'h0, instruction[10:6]};
                uses_rs = 1'b0;
              end
              FN_JR: begin
                is_jr = 1'b1;
                uses_rt = 1'b0;
                d.wen = 1'b0;
                d.wsel = '0;
              end
              default: known = 1'b0;
            endcase
          end
          OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
            d.alusrc = 1'b1;
            d.wen = 1'b1;
            d.wsel = rt;
            d.imm = sext;
            d.memread = (op == OP_LW);
            uses_rs = (op != OP_LUI);
            case (op)
              OP_SLTI:  d.aluop = ALU_SLT;
              OP_SLTIU: d.aluop = ALU_SLTU;
              OP_ANDI:  begin d.aluop = ALU_AND; d.imm = zext; end
              OP_ORI:   begin d.aluop = ALU_OR;  d.imm = zext; end
              OP_XORI:  begin d.aluop = ALU_XOR; d.imm = zext; end
              // A operand is forced to zero below since rs is not read
              OP_LUI:   begin d.aluop = ALU_OR;  d.imm = {instruction[15:0], 16'h0}; end
              default:  d.aluop = ALU_ADD;
            endcase
          end
          OP_SW: begin
            d.alusrc = 1'b1;
            d.memwrite = 1'b1;
            d.imm = sext;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
          end
          OP_BEQ, OP_BNE: begin
            d.aluop = ALU_SUB;
            d.imm = sext;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
            is_beq = (op == OP_BEQ);
            is_bne = (op == OP_BNE);
          end
          OP_J: is_j = 1'b1;
          OP_JAL: begin
            is_j = 1'b1;
            d.link = 1'b1;
            d.wen = 1'b1;
            d.wsel = 5'd31;
          end
          default: known = 1'b0;
        endcase
      end
      if (!known) begin
        d = '0;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
      end else begin
        // Unread sources are reported as $0 so EX forwarding never matches them
        d.npc = instr_npc;
        d.rs = uses_rs ? rs : '0;
        d.rt = uses_rt ? rt : '0;
        d.rdat1 = uses_rs ? rdat1 : '0;
        d.rdat2 = uses_rt ? rdat2 : '0;
      end
    end
  end

  assign take = is_j | is_jr | (is_beq & (rdat1 == rdat2)) | (is_bne & (rdat1 != rdat2));

  always_comb begin
    if (is_j)
      redirect_pc = {instr_npc[31:28], instruction[25:0], 2'b00};
    else if (is_jr)
      redirect_pc = rdat1;
    else
      redirect_pc = instr_npc + {sext[29:0], 2'b00};
  end

  assign load_use = ex_memread && hits(ex_wsel, uses_rs, uses_rt, rs, rt);
  assign cmp_haz  = (is_beq | is_bne | is_jr) &&
                    ((ex_wen && hits(ex_wsel, 1'b1, is_beq | is_bne, rs, rt)) ||
                     (mem_memread && hits(mem_wsel, 1'b1, is_beq | is_bne, rs, rt)));
  assign stall       = load_use | cmp_haz;
  assign redirect_en = take & ~stall & en;
  assign squash      = redirect_en;

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      q    <= '0;
      halt <= 1'b0;
    end else if (en) begin
      if (stall) begin
        q <= '0;
      end else begin
        q <= d;
        if (d.halt)
          halt <= 1'b1;
      end
    end
  end

  assign dx_npc      = q.npc;
  assign dx_rdat1    = q.rdat1;
  assign dx_rdat2    = q.rdat2;
  assign dx_imm      = q.imm;
  assign dx_rs       = q.rs;
  assign dx_rt       = q.rt;
  assign dx_wsel     = q.wsel;
  assign dx_aluop    = q.aluop;
  assign dx_alusrc   = q.alusrc;
  assign dx_shift    = q.shift;
  assign dx_wen      = q.wen;
  assign dx_memread  = q.memread;
  assign dx_memwrite = q.memwrite;
  assign dx_link     = q.link;
  assign dx_halt     = q.halt;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents queued per cycle,
// popped after each edge; combinational outputs checked before the edge.
module tb_decode_stage;
  import cpu_types_pkg::*;

  typedef struct packed {
    word_t    npc, rdat1, rdat2, imm;
    regbits_t rs, rt, wsel;
    aluop_t   aluop;
    logic     alusrc, shift, wen, memread, memwrite, link, halt;
  } dx_t;

  // flag field order: alusrc shift wen memread memwrite link halt
  localparam logic [6:0] F_NONE = 7'b0000000;
  localparam logic [6:0] F_WEN  = 7'b0010000;
  localparam logic [6:0] F_IMM  = 7'b1010000;
  localparam logic [6:0] F_SHFT = 7'b0110000;
  localparam logic [6:0] F_JAL  = 7'b0010010;
  localparam logic [6:0] F_HALT = 7'b0000001;

  logic     CLK = 1'b0, nRST = 1'b0, en = 1'b1;
  word_t    instruction = '0, instr_npc = '0, wb_wdat = '0;
  logic     wb_wen = 1'b0, ex_wen = 1'b0, ex_memread = 1'b0, mem_memread = 1'b0;
  regbits_t wb_wsel = '0, ex_wsel = '0, mem_wsel = '0;
  logic     stall, redirect_en, squash, halt;
  word_t    redirect_pc, dx_npc, dx_rdat1, dx_rdat2, dx_imm;
  regbits_t dx_rs, dx_rt, dx_wsel;
  aluop_t   dx_aluop;
  logic     dx_alusrc, dx_shift, dx_wen, dx_memread, dx_memwrite, dx_link, dx_halt;

  int  vectors = 0, miscompares = 0;
  dx_t sb[$];
  dx_t got, exp, held;

  decode_stage #(.HALT_WORD(32'hFFFFFFFF)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .instruction(instruction), .instr_npc(instr_npc),
    .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
    .ex_wen(ex_wen), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
    .mem_memread(mem_memread), .mem_wsel(mem_wsel),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc), .squash(squash),
    .halt(halt), .dx_npc(dx_npc), .dx_rdat1(dx_rdat1), .dx_rdat2(dx_rdat2), .dx_imm(dx_imm),
    .dx_rs(dx_rs), .dx_rt(dx_rt), .dx_wsel(dx_wsel), .dx_aluop(dx_aluop),
    .dx_alusrc(dx_alusrc), .dx_shift(dx_shift), .dx_wen(dx_wen), .dx_memread(dx_memread),
    .dx_memwrite(dx_memwrite), .dx_link(dx_link), .dx_halt(dx_halt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic word_t rtype(logic [4:0] s, logic [4:0] t, logic [4:0] d, logic [4:0] sh, logic [5:0] f);
    return {6'h00, s, t, d, sh, f};
  endfunction

  function automatic word_t itype(logic [5:0] o, logic [4:0] s, logic [4:0] t, logic [15:0] i);
    return {o, s, t, i};
  endfunction

  function automatic word_t jtype(logic [5:0] o, logic [25:0] tg);
    return {o, tg};
  endfunction

  function automatic dx_t mk(word_t n, word_t r1, word_t r2, word_t im, regbits_t s, regbits_t t,
                             regbits_t w, aluop_t a, logic [6:0] f);
    dx_t x;
    x.npc = n; x.rdat1 = r1; x.rdat2 = r2; x.imm = im;
    x.rs = s; x.rt = t; x.wsel = w; x.aluop = a;
    {x.alusrc, x.shift, x.wen, x.memread, x.memwrite, x.link, x.halt} = f;
    return x;
  endfunction

  function automatic dx_t sample();
    return {dx_npc, dx_rdat1, dx_rdat2, dx_imm, dx_rs, dx_rt, dx_wsel, dx_aluop,
            dx_alusrc, dx_shift, dx_wen, dx_memread, dx_memwrite, dx_link, dx_halt};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    got = sample();
  endtask

  task automatic test_reset();
    #1;
    sb.push_back('0);
    got = sample(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL reset_dx: got %h want %h", got, exp); end
    vectors++;
    if ({stall, redirect_en, squash, halt, redirect_pc} !== 36'h0) begin
      miscompares++; $display("FAIL reset_ctl: got %h want 0", {stall, redirect_en, squash, halt, redirect_pc});
    end
    nRST = 1'b1;
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL post_reset_nop: got %h want %h", got, exp); end
  endtask

  task automatic test_write_path();
    wb_wen = 1'b1; wb_wsel = 5'd6; wb_wdat = 32'h1;
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL wb_bubble: got %h want %h", got, exp); end

    wb_wsel = 5'd5; wb_wdat = 32'h1234;
    instruction = rtype(5, 6, 3, 0, 6'h21); instr_npc = 32'h200;
    sb.push_back(mk(32'h200, 32'h1234, 32'h1, 0, 5, 6, 3, ALU_ADD, F_WEN));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL bypass_addu: got %h want %h", got, exp); end

    wb_wen = 1'b0;
    instruction = rtype(5, 0, 7, 0, 6'h23); instr_npc = 32'h204;
    sb.push_back(mk(32'h204, 32'h1234, 0, 0, 5, 0, 7, ALU_SUB, F_WEN));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rf_read_subu: got %h want %h", got, exp); end

    instruction = rtype(0, 6, 8, 4, 6'h00); instr_npc = 32'h208;
    sb.push_back(mk(32'h208, 0, 32'h1, 32'h4, 0, 6, 8, ALU_SLL, F_SHFT));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL sll_shamt: got %h want %h", got, exp); end

    wb_wen = 1'b1; wb_wsel = 5'd0; wb_wdat = 32'hDEAD_BEEF;
    instruction = rtype(0, 0, 3, 0, 6'h21); instr_npc = 32'h20C;
    sb.push_back(mk(32'h20C, 0, 0, 0, 0, 0, 3, ALU_ADD, F_WEN));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL r0_bypass: got %h want %h", got, exp); end
    wb_wen = 1'b0;
    sb.push_back(mk(32'h20C, 0, 0, 0, 0, 0, 3, ALU_ADD, F_WEN));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL r0_write_drop: got %h want %h", got, exp); end
  endtask

  task automatic test_load_use();
    ex_memread = 1'b1; ex_wen = 1'b1; ex_wsel = 5'd4;
    instruction = rtype(4, 1, 2, 0, 6'h21); instr_npc = 32'h300;
    #1; vectors++;
    if ({stall, redirect_en, squash} !== 3'b100) begin
      miscompares++; $display("FAIL load_use_rs: got %b want 100", {stall, redirect_en, squash});
    end
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL load_use_bubble: got %h want %h", got, exp); end

    ex_wsel = 5'd1;
    #1; vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL load_use_rt: got %b want 1", stall); end
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL load_use_rt_bubble: got %h want %h", got, exp); end

    ex_wsel = 5'd0; instruction = rtype(0, 0, 2, 0, 6'h21);
    #1; vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL load_use_r0: got %b want 0", stall); end
    sb.push_back(mk(32'h300, 0, 0, 0, 0, 0, 2, ALU_ADD, F_WEN));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL load_use_r0_dx: got %h want %h", got, exp); end

    ex_wsel = 5'd4; instruction = itype(6'h09, 0, 4, 16'd5);
    #1; vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL load_use_dest_only: got %b want 0", stall); end
    sb.push_back(mk(32'h300, 0, 0, 32'h5, 0, 0, 4, ALU_ADD, F_IMM));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL addiu_dx: got %h want %h", got, exp); end

    ex_memread = 1'b0; ex_wen = 1'b0; ex_wsel = 5'd0;
    instruction = rtype(4, 1, 2, 0, 6'h21);
    #1; vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL load_use_clear: got %b want 0", stall); end
    sb.push_back(mk(32'h300, 0, 0, 0, 4, 1, 2, ALU_ADD, F_WEN));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL load_use_resume: got %h want %h", got, exp); end
  endtask

  task automatic test_branch();
    instruction = '0;
    wb_wen = 1'b1; wb_wsel = 5'd1; wb_wdat = 32'd7;
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL wb1_bubble: got %h want %h", got, exp); end
    wb_wsel = 5'd2;
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL wb2_bubble: got %h want %h", got, exp); end
    wb_wen = 1'b0;

    instruction = itype(6'h04, 1, 2, 16'd3); instr_npc = 32'h104;
    #1; vectors++;
    if ({stall, redirect_en, squash, redirect_pc} !== {3'b011, 32'h110}) begin
      miscompares++; $display("FAIL beq_taken: got %h want %h", {stall, redirect_en, squash, redirect_pc}, {3'b011, 32'h110});
    end
    sb.push_back(mk(32'h104, 7, 7, 3, 1, 2, 0, ALU_SUB, F_NONE));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL beq_dx: got %h want %h", got, exp); end

    instruction = itype(6'h05, 1, 2, 16'd3);
    #1; vectors++;
    if ({stall, redirect_en, squash} !== 3'b000) begin
      miscompares++; $display("FAIL bne_not_taken: got %b want 000", {stall, redirect_en, squash});
    end
    sb.push_back(mk(32'h104, 7, 7, 3, 1, 2, 0, ALU_SUB, F_NONE));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL bne_dx: got %h want %h", got, exp); end

    instruction = itype(6'h05, 1, 0, 16'hFFFF);
    #1; vectors++;
    if ({stall, redirect_en, squash, redirect_pc} !== {3'b011, 32'h100}) begin
      miscompares++; $display("FAIL bne_backward: got %h want %h", {stall, redirect_en, squash, redirect_pc}, {3'b011, 32'h100});
    end
    sb.push_back(mk(32'h104, 7, 0, 32'hFFFF_FFFF, 1, 0, 0, ALU_SUB, F_NONE));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL bne_backward_dx: got %h want %h", got, exp); end

    instruction = jtype(6'h03, 26'h40); instr_npc = 32'h8;
    #1; vectors++;
    if ({stall, redirect_en, squash, redirect_pc} !== {3'b011, 32'h100}) begin
      miscompares++; $display("FAIL jal_redirect: got %h want %h", {stall, redirect_en, squash, redirect_pc}, {3'b011, 32'h100});
    end
    sb.push_back(mk(32'h8, 0, 0, 0, 0, 0, 31, ALU_ADD, F_JAL));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL jal_dx: got %h want %h", got, exp); end

    instruction = rtype(1, 0, 0, 0, 6'h08); instr_npc = 32'h120;
    #1; vectors++;
    if ({redirect_en, redirect_pc} !== {1'b1, 32'h7}) begin
      miscompares++; $display("FAIL jr_redirect: got %h want %h", {redirect_en, redirect_pc}, {1'b1, 32'h7});
    end
    sb.push_back(mk(32'h120, 7, 0, 0, 1, 0, 0, ALU_ADD, F_NONE));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL jr_dx: got %h want %h", got, exp); end

    instruction = jtype(6'h02, 26'h3FF_FFFF); instr_npc = 32'hA000_0010;
    #1; vectors++;
    if ({redirect_en, redirect_pc} !== {1'b1, 32'hAFFF_FFFC}) begin
      miscompares++; $display("FAIL j_region: got %h want %h", {redirect_en, redirect_pc}, {1'b1, 32'hAFFF_FFFC});
    end
    sb.push_back(mk(32'hA000_0010, 0, 0, 0, 0, 0, 0, ALU_ADD, F_NONE));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL j_dx: got %h want %h", got, exp); end
  endtask

  task automatic test_branch_hazard();
    instruction = itype(6'h09, 1, 9, 16'hFFFE); instr_npc = 32'h400;
    held = mk(32'h400, 7, 0, 32'hFFFF_FFFE, 1, 0, 9, ALU_ADD, F_IMM);
    sb.push_back(held);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL addiu_neg: got %h want %h", got, exp); end

    ex_wen = 1'b1; ex_wsel = 5'd1; en = 1'b0;
    instruction = itype(6'h05, 1, 0, 16'd4); instr_npc = 32'h404;
    #1; vectors++;
    if ({stall, redirect_en, squash} !== 3'b100) begin
      miscompares++; $display("FAIL br_haz_en0: got %b want 100", {stall, redirect_en, squash});
    end
    sb.push_back(held);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL en0_hold: got %h want %h", got, exp); end

    en = 1'b1;
    #1; vectors++;
    if ({stall, redirect_en, squash} !== 3'b100) begin
      miscompares++; $display("FAIL br_haz_ex: got %b want 100", {stall, redirect_en, squash});
    end
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL br_haz_bubble: got %h want %h", got, exp); end

    ex_wen = 1'b0; ex_wsel = 5'd0; mem_memread = 1'b1; mem_wsel = 5'd1;
    #1; vectors++;
    if ({stall, redirect_en, squash} !== 3'b100) begin
      miscompares++; $display("FAIL br_haz_mem: got %b want 100", {stall, redirect_en, squash});
    end
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL br_haz_mem_bubble: got %h want %h", got, exp); end

    instruction = rtype(1, 0, 3, 0, 6'h21);
    #1; vectors++;
    if (stall !== 1'b0) begin miscompares++; $display("FAIL mem_load_alu: got %b want 0", stall); end
    held = mk(32'h404, 7, 0, 0, 1, 0, 3, ALU_ADD, F_WEN);
    sb.push_back(held);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL mem_load_alu_dx: got %h want %h", got, exp); end

    mem_memread = 1'b0; mem_wsel = 5'd0; en = 1'b0;
    instruction = itype(6'h05, 1, 0, 16'd4);
    #1; vectors++;
    if ({stall, redirect_en, squash} !== 3'b000) begin
      miscompares++; $display("FAIL en0_mask: got %b want 000", {stall, redirect_en, squash});
    end
    sb.push_back(held);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL en0_hold2: got %h want %h", got, exp); end

    en = 1'b1;
    #1; vectors++;
    if ({stall, redirect_en, squash, redirect_pc} !== {3'b011, 32'h414}) begin
      miscompares++; $display("FAIL bne_release: got %h want %h", {stall, redirect_en, squash, redirect_pc}, {3'b011, 32'h414});
    end
    sb.push_back(mk(32'h404, 7, 0, 4, 1, 0, 0, ALU_SUB, F_NONE));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL bne_release_dx: got %h want %h", got, exp); end

    ex_wen = 1'b1; ex_wsel = 5'd1;
    instruction = rtype(1, 0, 0, 0, 6'h08);
    #1; vectors++;
    if ({stall, redirect_en} !== 2'b10) begin
      miscompares++; $display("FAIL jr_haz: got %b want 10", {stall, redirect_en});
    end
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL jr_haz_bubble: got %h want %h", got, exp); end
    ex_wen = 1'b0; ex_wsel = 5'd0;
  endtask

  task automatic test_halt();
    instruction = 32'hFFFF_FFFF; instr_npc = 32'h500;
    #1; vectors++;
    if ({halt, stall} !== 2'b00) begin miscompares++; $display("FAIL halt_pre: got %b want 00", {halt, stall}); end
    sb.push_back(mk(32'h500, 0, 0, 0, 0, 0, 0, ALU_ADD, F_HALT));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL halt_dx: got %h want %h", got, exp); end
    vectors++;
    if (halt !== 1'b1) begin miscompares++; $display("FAIL halt_set: got %b want 1", halt); end

    instruction = rtype(5, 6, 3, 0, 6'h21); instr_npc = 32'h504;
    for (int unsigned i = 0; i < 2; i++) begin
      sb.push_back('0);
      tick(); exp = sb.pop_front(); vectors++;
      if (got !== exp) begin miscompares++; $display("FAIL halt_bubble%0d: got %h want %h", i, got, exp); end
      vectors++;
      if (halt !== 1'b1) begin miscompares++; $display("FAIL halt_sticky%0d: got %b want 1", i, halt); end
    end

    nRST = 1'b0;
    #1;
    sb.push_back('0);
    got = sample(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL halt_reset_dx: got %h want %h", got, exp); end
    vectors++;
    if (halt !== 1'b0) begin miscompares++; $display("FAIL halt_reset: got %b want 0", halt); end
    nRST = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    ex_memread = 1'b1; ex_wen = 1'b1; ex_wsel = 5'd5;
    instruction = rtype(5, 6, 3, 0, 6'h21); instr_npc = 32'h600;
    #1; vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL mid_stall: got %b want 1", stall); end
    sb.push_back('0);
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL mid_stall_bubble: got %h want %h", got, exp); end

    nRST = 1'b0;
    #1;
    sb.push_back('0);
    got = sample(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL mid_stall_reset: got %h want %h", got, exp); end
    nRST = 1'b1;
    ex_memread = 1'b0; ex_wen = 1'b0; ex_wsel = 5'd0;
    sb.push_back(mk(32'h600, 0, 0, 0, 5, 6, 3, ALU_ADD, F_WEN));
    tick(); exp = sb.pop_front(); vectors++;
    if (got !== exp) begin miscompares++; $display("FAIL rf_cleared: got %h want %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_write_path();
    test_load_use();
    test_branch();
    test_branch_hazard();
    test_halt();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
